rc5_key_sched: RTL and testbench
================================

Name: rc5_key_sched

Overview:
- Generates the RC5-16/ROUNDS/16 expanded subkey table S[0..T-1] from the 128-bit user key, using the standard RC5 key schedule.
- Sits in front of the encrypt/decrypt datapath and replaces its hard-wired subkey constants.
- The datapath reads subkeys through a registered read port once key_valid is high.
- Iterative design: one mixing step per cycle.

Parameters:
- ROUNDS, 16: RC5 round count. T = 2*ROUNDS+2 = 34 subkeys.
- P16, 16'hB7E1: RC5 magic constant P for w=16.
- Q16, 16'h9E37: RC5 magic constant Q for w=16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to expand key; sampled only in IDLE.
- key  input  128  user key; sampled on the start edge only.
- busy  output  1  high from LOAD_L through MIX.
- done  output  1  one-cycle pulse when the table is complete.
- key_valid  output  1  table holds a fully expanded key.
- rd_addr  input  6  subkey index 0..T-1.
- rd_data  output  16  S[rd_addr], registered, 1-cycle latency.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, done=0, key_valid=0, rd_data=0.
  - All S, L, A, B, i, j, counters cleared.
- States: IDLE -> LOAD_L -> INIT_S -> MIX -> DONE -> IDLE.
- IDLE:
  - start=1 latches key, clears key_valid, goes to LOAD_L.
  - start=0 holds state.
- LOAD_L (1 cycle): L[j] = key[16j+15:16j] for j=0..7 (little-endian bytes, K[0]=key[7:0]).
- INIT_S (T=34 cycles):
  - S[0]=P16, S[k]=S[k-1]+Q16, all mod 2^16.
  - Uses a running accumulator; no multiplier.
- MIX (3*max(T,8)=102 cycles): each cycle, with A, B, i, j starting at 0:
  - A' = (S[i]+A+B) <<< 3, written to S[i].
  - B' = (L[j]+A'+B) <<< ((A'+B) mod 16), written to L[j].
  - i = (i+1) mod T, j = (j+1) mod 8.
  - All adds are 16-bit wraparound. Rotates are 16-bit circular.
  - The B update uses the new A' in the same cycle.
- DONE (1 cycle): done=1, key_valid=1, busy=0, then IDLE.
- Latency: the start edge is cycle 0; busy is high for cycles 1..137; done is high in cycle 138.
- Read port:
  - rd_data <= key_valid ? S[rd_addr] : 16'd0 on every clock.
  - rd_addr >= T returns 0.
  - Reads are always legal; during busy they return 0.
- start while busy, or in DONE: ignored, with no effect on the run in progress.
- start in IDLE with key_valid=1: table is invalidated immediately and recomputed.
- Reset mid-operation: abort to IDLE with the table cleared; no done pulse.
- key changes after the start edge have no effect.

Optional Feature:
- Macro: RC5_KEY_SCHED_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - zeroize=1 in any state: next cycle state=IDLE, all S/L/A/B cleared, key_valid=0, busy=0, no done pulse.
  - zeroize has priority over start in the same cycle.
- Undefined:
  - Port absent. The table is cleared only by rst or overwritten by a new start.

Test Plan:
- Reset then idle: rst=0 for 3 cycles mid-run -> busy=0, done=0, key_valid=0, rd_data=0 for all addresses.
- key=128'h0, start pulse:
  - busy high exactly 137 cycles, done high in cycle 138.
  - All 34 rd_data words match the golden RC5-16/16/16 C model.
  - S[0] ≠ 16'hB7E1, confirming the mix ran.
- key=128'h0F0E0D0C0B0A09080706050403020100, start:
  - All 34 words match the golden model.
  - Encrypt/decrypt round trip of 32'h12345678 through the datapath returns 32'h12345678.
- start pulses at cycles 5 and 60 of an active run, with key changed -> table equals the first key's expansion; a single done pulse.
- Reset asserted at cycle 70 of MIX, then restart with the same key -> no done before reset; final table is identical to an uninterrupted run.
- With RC5_KEY_SCHED_ZEROIZE_EN: zeroize=1 at cycle 50, and separately after done -> key_valid=0, rd_data=0 at every address, no done pulse; a subsequent start completes normally.

Source files
------------

// File: rtl/rc5_key_sched.sv
// RC5-16/ROUNDS/16 key expansion: iterative, one S-init or mix step per cycle, registered subkey read port.
// Optional zeroize port under macro RC5_KEY_SCHED_ZEROIZE_EN.
module rc5_key_sched #(
  parameter int          ROUNDS = 16,
  parameter logic [15:0] P16    = 16'hB7E1,
  parameter logic [15:0] Q16    = 16'h9E37
) (
  input  logic         clk,
  input  logic         rst,
`ifdef RC5_KEY_SCHED_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [5:0]   rd_addr,
  output logic [15:0]  rd_data
);

  localparam int T     = 2 * ROUNDS + 2;
  localparam int MIX_N = 3 * ((T > 8) ? T : 8);
  localparam int CW    = $clog2(MIX_N + 1);

  typedef enum logic [2:0] {IDLE, LOAD_L, INIT_S, MIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   s_q [T];
  logic [15:0]   s_d [T];
  logic [15:0]   l_q [8];
  logic [15:0]   l_d [8];
  logic [15:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [5:0]    i_q, i_d;
  logic [2:0]    j_q, j_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_valid_q, key_valid_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          zero_req;

`ifdef RC5_KEY_SCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
    rotl16 = (x << n) | (x >> (5'd16 - {1'b0, n}));
  endfunction

  // One mixing step; B uses the freshly computed A in the same cycle.
  logic [15:0] a_new, b_new;
  logic [3:0]  rot_amt;
  always_comb begin
    a_new   = rotl16(s_q[i_q] + a_q + b_q, 4'd3);
    rot_amt = a_new[3:0] + b_q[3:0];
    b_new   = rotl16(l_q[j_q] + a_new + b_q, rot_amt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      for (int k = 0; k < T; k++) s_q[k] <= '0;
      for (int k = 0; k < 8; k++) l_q[k] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      l_q         <= l_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_L;
      LOAD_L:  state_d = INIT_S;
      INIT_S:  if (i_q == 6'(T - 1)) state_d = MIX;
      MIX:     if (cnt_q == CW'(MIX_N - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (zero_req) state_d = IDLE;
  end

  always_comb begin
    s_d         = s_q;
    l_d         = l_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid_q;
    case (state_q)
      IDLE: begin
        // L is captured straight from the key on the start edge, so later key changes are harmless.
        if (start) begin
          for (int k = 0; k < 8; k++) l_d[k] = key[16*k +: 16];
          key_valid_d = 1'b0;
        end
      end
      LOAD_L: begin
        acc_d = P16;
        a_d   = '0;
        b_d   = '0;
        i_d   = '0;
        j_d   = '0;
        cnt_d = '0;
      end
      INIT_S: begin
        s_d[i_q] = acc_q;
        acc_d    = acc_q + Q16;
        i_d      = (i_q == 6'(T - 1)) ? 6'd0 : i_q + 6'd1;
      end
      MIX: begin
        s_d[i_q] = a_new;
        l_d[j_q] = b_new;
        a_d      = a_new;
        b_d      = b_new;
        i_d      = (i_q == 6'(T - 1)) ? 6'd0 : i_q + 6'd1;
        j_d      = j_q + 3'd1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MIX_N - 1)) key_valid_d = 1'b1;
      end
      default: ;
    endcase
    if (zero_req) begin
      for (int k = 0; k < T; k++) s_d[k] = '0;
      for (int k = 0; k < 8; k++) l_d[k] = '0;
      a_d         = '0;
      b_d         = '0;
      acc_d       = '0;
      i_d         = '0;
      j_d         = '0;
      cnt_d       = '0;
      key_valid_d = 1'b0;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (key_valid_q && (rd_addr < 6'(T))) rd_data_d = s_q[rd_addr];
  end

  always_comb begin
    busy      = (state_q == LOAD_L) || (state_q == INIT_S) || (state_q == MIX);
    done      = (state_q == DONE);
    key_valid = key_valid_q;
    rd_data   = rd_data_q;
  end

endmodule

// File: tb/tb_rc5_key_sched.sv
// Directed bench for rc5_key_sched: latency, table contents against a reference expansion, restart/abort cases.
module tb_rc5_key_sched;

  typedef logic [15:0] tab_t [34];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy, done, key_valid;
  logic [5:0]   rd_addr;
  logic [15:0]  rd_data;
`ifdef RC5_KEY_SCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int   checks = 0;
  int   errors = 0;
  tab_t exp_s;
  tab_t dut_s;

  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] KEY_SEQ  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] KEY_ALT  = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;

  rc5_key_sched dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RC5_KEY_SCHED_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rol(input logic [15:0] x, input int n);
    int m;
    m = n & 15;
    if (m == 0) return x;
    return (x << m) | (x >> (16 - m));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] x, input int n);
    return rol(x, 16 - (n & 15));
  endfunction

  // Textbook RC5 key schedule, w=16, r=16, b=16.
  task automatic model_expand(input logic [127:0] k);
    logic [15:0] l [8];
    logic [15:0] a, b, tmp;
    int          i, j;
    for (int w = 0; w < 8; w++) l[w] = k[16*w +: 16];
    exp_s[0] = 16'hB7E1;
    for (int t = 1; t < 34; t++) exp_s[t] = exp_s[t-1] + 16'h9E37;
    a = '0; b = '0; i = 0; j = 0;
    for (int n = 0; n < 102; n++) begin
      a        = rol(exp_s[i] + a + b, 3);
      exp_s[i] = a;
      tmp      = a + b;
      b        = rol(l[j] + tmp, int'(tmp[3:0]));
      l[j]     = b;
      i        = (i + 1) % 34;
      j        = (j + 1) % 8;
    end
  endtask

  function automatic logic [31:0] rc5_enc(input tab_t s, input logic [31:0] pt);
    logic [15:0] a, b;
    a = pt[15:0] + s[0];
    b = pt[31:16] + s[1];
    for (int r = 1; r <= 16; r++) begin
      a = rol(a ^ b, int'(b[3:0])) + s[2*r];
      b = rol(b ^ a, int'(a[3:0])) + s[2*r+1];
    end
    return {b, a};
  endfunction

  function automatic logic [31:0] rc5_dec(input tab_t s, input logic [31:0] ct);
    logic [15:0] a, b;
    a = ct[15:0];
    b = ct[31:16];
    for (int r = 16; r >= 1; r--) begin
      b = ror(b - s[2*r+1], int'(a[3:0])) ^ a;
      a = ror(a - s[2*r], int'(b[3:0])) ^ b;
    end
    b = b - s[1];
    a = a - s[0];
    return {b, a};
  endfunction

  // Leaves the bench at the falling edge of cycle 1 (start edge = cycle 0).
  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_done(output int busy_cnt, output int done_cyc, output int done_cnt);
    busy_cnt = 0; done_cyc = 0; done_cnt = 0;
    for (int c = 1; c <= 160; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      @(negedge clk);
    end
  endtask

  task automatic read_word(input int a, output logic [15:0] d);
    rd_addr = 6'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic read_table();
    for (int a = 0; a < 34; a++) read_word(a, dut_s[a]);
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
    checks++; if (rd_data !== 16'h0)  begin errors++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
  endtask

  task automatic test_zero_key();
    int bc, dc, dn;
    model_expand(KEY_ZERO);
    do_start(KEY_ZERO);
    run_to_done(bc, dc, dn);
    checks++; if (bc !== 137) begin errors++; $display("FAIL zero_busy_cycles got %0d want 137", bc); end
    checks++; if (dc !== 138) begin errors++; $display("FAIL zero_done_cycle got %0d want 138", dc); end
    checks++; if (dn !== 1)   begin errors++; $display("FAIL zero_done_pulses got %0d want 1", dn); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL zero_key_valid got %b want 1", key_valid); end
    read_table();
    for (int a = 0; a < 34; a++) begin
      checks++;
      if (dut_s[a] !== exp_s[a]) begin errors++; $display("FAIL zero_S[%0d] got %h want %h", a, dut_s[a], exp_s[a]); end
    end
    checks++; if (dut_s[0] === 16'hB7E1) begin errors++; $display("FAIL zero_S0_mixed got %h want not b7e1", dut_s[0]); end
  endtask

  task automatic test_seq_key();
    int          bc, dc, dn;
    logic [31:0] ct_dut, ct_ref, pt_back;
    model_expand(KEY_SEQ);
    do_start(KEY_SEQ);
    run_to_done(bc, dc, dn);
    checks++; if (dc !== 138) begin errors++; $display("FAIL seq_done_cycle got %0d want 138", dc); end
    read_table();
    for (int a = 0; a < 34; a++) begin
      checks++;
      if (dut_s[a] !== exp_s[a]) begin errors++; $display("FAIL seq_S[%0d] got %h want %h", a, dut_s[a], exp_s[a]); end
    end
    ct_dut  = rc5_enc(dut_s, 32'h12345678);
    ct_ref  = rc5_enc(exp_s, 32'h12345678);
    pt_back = rc5_dec(dut_s, ct_dut);
    checks++; if (ct_dut !== ct_ref)        begin errors++; $display("FAIL seq_cipher got %h want %h", ct_dut, ct_ref); end
    checks++; if (pt_back !== 32'h12345678) begin errors++; $display("FAIL seq_roundtrip got %h want 12345678", pt_back); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] d;
    read_word(34, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL oor_34 got %h want 0000", d); end
    read_word(63, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL oor_63 got %h want 0000", d); end
    read_word(33, d);
    checks++; if (d !== exp_s[33]) begin errors++; $display("FAIL oor_33 got %h want %h", d, exp_s[33]); end
  endtask

  // Extra starts at cycles 5, 60 and in DONE, with a changed key, must be ignored.
  task automatic test_back_to_back();
    int dn, dc;
    dn = 0; dc = 0;
    model_expand(KEY_SEQ);
    do_start(KEY_SEQ);
    for (int c = 1; c <= 160; c++) begin
      if (done) begin
        dn++;
        if (dc == 0) dc = c;
      end
      key   = KEY_ALT;
      start = (c == 4) || (c == 59) || (c == 138);
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (dn !== 1)   begin errors++; $display("FAIL b2b_done_pulses got %0d want 1", dn); end
    checks++; if (dc !== 138) begin errors++; $display("FAIL b2b_done_cycle got %0d want 138", dc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
    read_table();
    for (int a = 0; a < 34; a++) begin
      checks++;
      if (dut_s[a] !== exp_s[a]) begin errors++; $display("FAIL b2b_S[%0d] got %h want %h", a, dut_s[a], exp_s[a]); end
    end
  endtask

  task automatic test_restart_invalidate();
    int          bc, dc, dn;
    logic [15:0] d;
    model_expand(KEY_ALT);
    do_start(KEY_ALT);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL restart_key_valid got %b want 0", key_valid); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
    read_word(0, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL restart_read_busy got %h want 0000", d); end
    run_to_done(bc, dc, dn);
    checks++; if (dn !== 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", dn); end
    read_word(5, d);
    checks++; if (d !== exp_s[5]) begin errors++; $display("FAIL restart_S5 got %h want %h", d, exp_s[5]); end
  endtask

  // Reset at cycle 70 of MIX (MIX begins in cycle 36).
  task automatic test_reset_mid();
    int          bc, dc, dn, early;
    logic [15:0] d;
    int          nz;
    early = 0; nz = 0;
    model_expand(KEY_SEQ);
    do_start(KEY_SEQ);
    for (int c = 1; c < 106; c++) begin
      if (done) early++;
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) early++;
    end
    rst = 1'b1;
    checks++; if (early !== 0)        begin errors++; $display("FAIL rstmid_done_pulses got %0d want 0", early); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_key_valid got %b want 0", key_valid); end
    for (int a = 0; a < 34; a++) begin
      read_word(a, d);
      if (d !== 16'h0) nz++;
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL rstmid_reads nonzero_words %0d want 0", nz); end
    do_start(KEY_SEQ);
    run_to_done(bc, dc, dn);
    checks++; if (dc !== 138) begin errors++; $display("FAIL rstmid_restart_done got %0d want 138", dc); end
    read_table();
    for (int a = 0; a < 34; a++) begin
      checks++;
      if (dut_s[a] !== exp_s[a]) begin errors++; $display("FAIL rstmid_S[%0d] got %h want %h", a, dut_s[a], exp_s[a]); end
    end
  endtask

`ifdef RC5_KEY_SCHED_ZEROIZE_EN
  task automatic test_zeroize();
    int          bc, dc, dn, nz;
    logic [15:0] d;
    dn = 0; nz = 0;
    model_expand(KEY_ZERO);
    do_start(KEY_SEQ);
    for (int c = 1; c <= 160; c++) begin
      if (done) dn++;
      zeroize = (c == 49);
      @(negedge clk);
    end
    zeroize = 1'b0;
    checks++; if (dn !== 0)           begin errors++; $display("FAIL zrun_done_pulses got %0d want 0", dn); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL zrun_busy got %b want 0", busy); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL zrun_key_valid got %b want 0", key_valid); end
    do_start(KEY_ZERO);
    run_to_done(bc, dc, dn);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL zdone_key_valid got %b want 0", key_valid); end
    for (int a = 0; a < 34; a++) begin
      read_word(a, d);
      if (d !== 16'h0) nz++;
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL zdone_reads nonzero_words %0d want 0", nz); end
    do_start(KEY_ZERO);
    run_to_done(bc, dc, dn);
    checks++; if (dc !== 138) begin errors++; $display("FAIL zre_done_cycle got %0d want 138", dc); end
    read_table();
    for (int a = 0; a < 34; a++) begin
      checks++;
      if (dut_s[a] !== exp_s[a]) begin errors++; $display("FAIL zre_S[%0d] got %h want %h", a, dut_s[a], exp_s[a]); end
    end
  endtask
`endif

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    key     = '0;
    rd_addr = '0;
`ifdef RC5_KEY_SCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_zero_key();
    test_seq_key();
    test_out_of_range();
    test_back_to_back();
    test_restart_invalidate();
    test_reset_mid();
`ifdef RC5_KEY_SCHED_ZEROIZE_EN
    test_zeroize();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
